// File: rtl/adc9252_pkg.sv
// Shared definitions for the AD9252 LVDS receive path: FSM encodings and frame constants.
package adc9252_pkg;

    localparam int               FCO_FRAME_W     = 14;
    localparam logic [13:0]      FCO_PATTERN_DEF = 14'h3F80;
    localparam int               LOSS_THRESH     = 4;

    // One-hot alignment FSM encoding
    typedef enum logic [5:0] {
        ST_IDLE   = 6'b000001,
        ST_CHECK  = 6'b000010,
        ST_SLIP   = 6'b000100,
        ST_SETTLE = 6'b001000,
        ST_LOCKED = 6'b010000,
        ST_FAIL   = 6'b100000
    } state_t;

endpackage

// File: rtl/fco_bitslip_align_if.sv
// Control/status bundle between the FCO alignment stage and its user.
interface fco_bitslip_align_if
    import adc9252_pkg::*;
#(
    parameter int FRAME_W = FCO_FRAME_W,
    parameter int SLIP_W  = 4
);
    logic               start;
    logic [FRAME_W-1:0] fco_frame;
    logic               bitslip;
    logic               fco_aligned;
    logic               align_fail;
    logic [SLIP_W-1:0]  slip_count;
    logic               lock_lost;

    modport master (
        output start, fco_frame,
        input  bitslip, fco_aligned, align_fail, slip_count, lock_lost
    );

    modport slave (
        input  start, fco_frame,
        output bitslip, fco_aligned, align_fail, slip_count, lock_lost
    );
endinterface

// File: rtl/fco_bitslip_align.sv
// Issues ISERDES bitslip pulses until the deserialized FCO word equals FCO_PATTERN.
// Define FCO_LOCK_MONITOR_EN to enable loss-of-lock detection while LOCKED.
module fco_bitslip_align
    import adc9252_pkg::*;
#(
    parameter int               FRAME_W     = FCO_FRAME_W,
    parameter logic [FRAME_W-1:0] FCO_PATTERN = FRAME_W'(FCO_PATTERN_DEF),
    parameter int               SETTLE_CYC  = 8,
    parameter int               MATCH_CNT   = 4,
    parameter int               MAX_SLIPS   = 14,
    parameter int               SLIP_W      = $clog2(MAX_SLIPS + 1)
) (
    input  logic                clk_div,
    input  logic                reset,
    fco_bitslip_align_if.slave  bus
);

    localparam int MATCH_W  = $clog2(MATCH_CNT + 1);
    localparam int SETTLE_W = $clog2(SETTLE_CYC + 1);

    state_t              state_reg, state_next;
    logic [MATCH_W-1:0]  match_cnt_reg, match_cnt_next;
    logic [SETTLE_W-1:0] settle_cnt_reg, settle_cnt_next;
    logic [SLIP_W-1:0]   slip_cnt_reg, slip_cnt_next;

    logic                bitslip_reg, bitslip_next;
    logic                aligned_reg, aligned_next;
    logic                fail_reg, fail_next;
    logic [SLIP_W-1:0]   slip_count_reg, slip_count_next;

    logic                frame_match;
    assign frame_match = (bus.fco_frame == FCO_PATTERN);

`ifdef FCO_LOCK_MONITOR_EN
    logic [2:0]          loss_cnt_reg, loss_cnt_next;
    logic                lost_evt_reg, lost_evt_next;
    logic                lock_lost_reg, lock_lost_next;
`endif

    // State and counter registers
    always_ff @(posedge clk_div or posedge reset) begin
        if (reset) begin
            state_reg      <= ST_IDLE;
            match_cnt_reg  <= '0;
            settle_cnt_reg <= '0;
            slip_cnt_reg   <= '0;
`ifdef FCO_LOCK_MONITOR_EN
            loss_cnt_reg   <= '0;
            lost_evt_reg   <= 1'b0;
`endif
        end else begin
            state_reg      <= state_next;
            match_cnt_reg  <= match_cnt_next;
            settle_cnt_reg <= settle_cnt_next;
            slip_cnt_reg   <= slip_cnt_next;
`ifdef FCO_LOCK_MONITOR_EN
            loss_cnt_reg   <= loss_cnt_next;
            lost_evt_reg   <= lost_evt_next;
`endif
        end
    end

    // Next-state and counter update
    always_comb begin
        state_next      = state_reg;
        match_cnt_next  = match_cnt_reg;
        settle_cnt_next = settle_cnt_reg;
        slip_cnt_next   = slip_cnt_reg;
`ifdef FCO_LOCK_MONITOR_EN
        loss_cnt_next   = loss_cnt_reg;
        lost_evt_next   = 1'b0;
`endif
        if (!bus.start) begin
            state_next = ST_IDLE;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    state_next     = ST_CHECK;
                    slip_cnt_next  = '0;
                    match_cnt_next = '0;
                end
                ST_CHECK: begin
                    if (frame_match) begin
                        if (match_cnt_reg == MATCH_W'(MATCH_CNT - 1)) begin
                            state_next     = ST_LOCKED;
                            match_cnt_next = '0;
`ifdef FCO_LOCK_MONITOR_EN
                            loss_cnt_next  = '0;
`endif
                        end else begin
                            match_cnt_next = match_cnt_reg + MATCH_W'(1);
                        end
                    end else begin
                        match_cnt_next = '0;
                        state_next     = (slip_cnt_reg == SLIP_W'(MAX_SLIPS)) ? ST_FAIL : ST_SLIP;
                    end
                end
                ST_SLIP: begin
                    slip_cnt_next   = slip_cnt_reg + SLIP_W'(1);
                    settle_cnt_next = SETTLE_W'(SETTLE_CYC);
                    state_next      = ST_SETTLE;
                end
                ST_SETTLE: begin
                    // The word is in flux after a slip; count out the window without looking at it
                    settle_cnt_next = settle_cnt_reg - SETTLE_W'(1);
                    if (settle_cnt_reg == SETTLE_W'(1)) begin
                        state_next     = ST_CHECK;
                        match_cnt_next = '0;
                    end
                end
                ST_LOCKED: begin
`ifdef FCO_LOCK_MONITOR_EN
                    if (frame_match) begin
                        loss_cnt_next = '0;
                    end else if (loss_cnt_reg == 3'(LOSS_THRESH - 1)) begin
                        loss_cnt_next  = '0;
                        lost_evt_next  = 1'b1;
                        slip_cnt_next  = '0;
                        match_cnt_next = '0;
                        state_next     = ST_CHECK;
                    end else begin
                        loss_cnt_next = loss_cnt_reg + 3'd1;
                    end
`endif
                end
                ST_FAIL: begin
                    state_next = ST_FAIL;
                end
                default: begin
                    state_next = ST_IDLE;
                end
            endcase
        end
    end

    // Moore output decode
    always_comb begin
        bitslip_next    = (state_reg == ST_SLIP);
        aligned_next    = (state_reg == ST_LOCKED);
        fail_next       = (state_reg == ST_FAIL);
        slip_count_next = slip_cnt_reg;
`ifdef FCO_LOCK_MONITOR_EN
        lock_lost_next  = lost_evt_reg;
`endif
    end

    // Registered outputs; the async reset drops them immediately
    always_ff @(posedge clk_div or posedge reset) begin
        if (reset) begin
            bitslip_reg    <= 1'b0;
            aligned_reg    <= 1'b0;
            fail_reg       <= 1'b0;
            slip_count_reg <= '0;
`ifdef FCO_LOCK_MONITOR_EN
            lock_lost_reg  <= 1'b0;
`endif
        end else begin
            bitslip_reg    <= bitslip_next;
            aligned_reg    <= aligned_next;
            fail_reg       <= fail_next;
            slip_count_reg <= slip_count_next;
`ifdef FCO_LOCK_MONITOR_EN
            lock_lost_reg  <= lock_lost_next;
`endif
        end
    end

    assign bus.bitslip     = bitslip_reg;
    assign bus.fco_aligned = aligned_reg;
    assign bus.align_fail  = fail_reg;
    assign bus.slip_count  = slip_count_reg;
`ifdef FCO_LOCK_MONITOR_EN
    assign bus.lock_lost   = lock_lost_reg;
`else
    assign bus.lock_lost   = 1'b0;
`endif

endmodule
